// File: rtl/rv_fetch_pkg.sv
// rtl/rv_fetch_pkg.sv - shared fetch types: predictor counter, table entry, default constants
package rv_fetch_pkg;

  localparam int          DEF_XLEN         = 32;
  localparam logic [31:0] DEF_RESET_VECTOR = 32'h0000_0000;
  // Entry fields are sized for the widest supported XLEN; narrower builds leave upper bits constant.
  localparam int          MAX_XLEN         = 64;

  typedef enum logic [1:0] {
    STRONG_NT = 2'd0,
    WEAK_NT   = 2'd1,
    WEAK_T    = 2'd2,
    STRONG_T  = 2'd3
  } ctr_t;

  typedef struct packed {
    logic                valid;
    logic [MAX_XLEN-1:0] tag;
    logic [MAX_XLEN-1:0] target;
    ctr_t                ctr;
  } bht_entry_t;

  function automatic ctr_t ctr_next(input ctr_t c, input logic taken);
    ctr_t n;
    n = c;
    if (taken) begin
      if (c != STRONG_T) n = ctr_t'(c + 2'd1);
    end else begin
      if (c != STRONG_NT) n = ctr_t'(c - 2'd1);
    end
    return n;
  endfunction

endpackage

// File: rtl/branch_table.sv
// rtl/branch_table.sv - direct-mapped branch table: combinational lookup port, registered update port
module branch_table
  import rv_fetch_pkg::*;
#(
  parameter int XLEN        = DEF_XLEN,
  parameter int BHT_ENTRIES = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] lookup_pc,
  output logic            hit_taken,
  output logic [XLEN-1:0] hit_target,
  input  logic            upd_en,
  input  logic [XLEN-1:0] upd_pc,
  input  logic            upd_taken,
  input  logic [XLEN-1:0] upd_target
);

  localparam int IDX_W = $clog2(BHT_ENTRIES);

  bht_entry_t          tbl [BHT_ENTRIES];
  logic [IDX_W-1:0]    l_idx;
  logic [IDX_W-1:0]    u_idx;
  logic [MAX_XLEN-1:0] l_tag;
  logic [MAX_XLEN-1:0] u_tag;
  logic [MAX_XLEN-1:0] u_target;
  bht_entry_t          l_e;
  bht_entry_t          u_e;
  logic                u_hit;
  logic                unused_bits;

  assign l_idx = lookup_pc[IDX_W+1:2];
  assign l_tag = MAX_XLEN'(lookup_pc[XLEN-1:IDX_W+2]);
  assign l_e   = tbl[l_idx];

  assign hit_taken  = l_e.valid && (l_e.tag == l_tag) && l_e.ctr[1];
  assign hit_target = hit_taken ? l_e.target[XLEN-1:0] : '0;

  assign u_idx    = upd_pc[IDX_W+1:2];
  assign u_tag    = MAX_XLEN'(upd_pc[XLEN-1:IDX_W+2]);
  assign u_target = MAX_XLEN'({upd_target[XLEN-1:2], 2'b00});
  assign u_e      = tbl[u_idx];
  assign u_hit    = u_e.valid && (u_e.tag == u_tag);

  assign unused_bits = ^{lookup_pc[1:0], upd_pc[1:0], upd_target[1:0], l_e.target, u_e.target};

  // Only valid bits are reset; tag/target/counter are qualified by valid.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < BHT_ENTRIES; i++) tbl[i].valid <= 1'b0;
    end else if (upd_en) begin
      if (u_hit) begin
        tbl[u_idx].ctr <= ctr_next(u_e.ctr, upd_taken);
        if (upd_taken) tbl[u_idx].target <= u_target;
      end else if (upd_taken) begin
        tbl[u_idx] <= '{valid: 1'b1, tag: u_tag, target: u_target, ctr: WEAK_T};
      end
    end
  end

endmodule

// File: rtl/next_pc_unit.sv
// rtl/next_pc_unit.sv - fetch PC sequencer; branch prediction table present only with NEXT_PC_PREDICT_EN
module next_pc_unit
  import rv_fetch_pkg::*;
#(
  parameter int              XLEN         = DEF_XLEN,
  parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(DEF_RESET_VECTOR),
  parameter int              BHT_ENTRIES  = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  input  logic            update_en_i,
  input  logic [XLEN-1:0] update_pc_i,
  input  logic            update_taken_i,
  input  logic [XLEN-1:0] update_target_i,
  output logic [XLEN-1:0] pc_o,
  output logic            pred_taken_o,
  output logic [XLEN-1:0] pred_target_o
);

  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] pc_next;
  logic            unused_redirect_low;

`ifdef NEXT_PC_PREDICT_EN
  branch_table #(
    .XLEN        (XLEN),
    .BHT_ENTRIES (BHT_ENTRIES)
  ) u_bht (
    .clk        (clk),
    .rst        (rst),
    .lookup_pc  (pc_q),
    .hit_taken  (pred_taken_o),
    .hit_target (pred_target_o),
    .upd_en     (update_en_i),
    .upd_pc     (update_pc_i),
    .upd_taken  (update_taken_i),
    .upd_target (update_target_i)
  );
`else
  localparam int unused_bht_entries = BHT_ENTRIES;
  logic unused_update;

  assign pred_taken_o  = 1'b0;
  assign pred_target_o = '0;
  assign unused_update = ^{update_en_i, update_pc_i, update_taken_i, update_target_i};
`endif

  assign unused_redirect_low = ^redirect_pc_i[1:0];

  always_comb begin
    pc_next = pc_q + XLEN'(4);
    if (redirect_i)        pc_next = {redirect_pc_i[XLEN-1:2], 2'b00};
    else if (stall_i)      pc_next = pc_q;
    else if (pred_taken_o) pc_next = pred_target_o;
  end

  always_ff @(posedge clk) begin
    if (!rst) pc_q <= {RESET_VECTOR[XLEN-1:2], 2'b00};
    else      pc_q <= pc_next;
  end

  assign pc_o = pc_q;

endmodule

// File: tb/tb_next_pc_unit.sv
// tb/tb_next_pc_unit.sv - directed plus random checks of next_pc_unit against a table model
module tb_next_pc_unit;

`ifdef NEXT_PC_PREDICT_EN
  localparam bit PRED_ON = 1'b1;
`else
  localparam bit PRED_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, stall_i, redirect_i, update_en_i, update_taken_i;
  logic [31:0] redirect_pc_i, update_pc_i, update_target_i;
  logic [31:0] pc_o, pred_target_o;
  logic        pred_taken_o;

  int tests = 0;
  int fails = 0;

  bit          mv   [16];
  logic [31:0] mtag [16];
  logic [31:0] mtgt [16];
  int          mctr [16];
  logic [31:0] mpc;
  bit          known = 1'b0;

  always #5 clk = ~clk;

  next_pc_unit #(.XLEN(32), .RESET_VECTOR(32'h0), .BHT_ENTRIES(16)) dut (
    .clk             (clk),
    .rst             (rst),
    .stall_i         (stall_i),
    .redirect_i      (redirect_i),
    .redirect_pc_i   (redirect_pc_i),
    .update_en_i     (update_en_i),
    .update_pc_i     (update_pc_i),
    .update_taken_i  (update_taken_i),
    .update_target_i (update_target_i),
    .pc_o            (pc_o),
    .pred_taken_o    (pred_taken_o),
    .pred_target_o   (pred_target_o)
  );

  function automatic void lookup(input logic [31:0] pc, output bit t, output logic [31:0] tg);
    int i;
    i  = int'((pc >> 2) % 16);
    t  = PRED_ON && mv[i] && (mtag[i] == (pc >> 6)) && (mctr[i] >= 2);
    tg = t ? mtgt[i] : 32'h0;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc(input bit r, input bit st, input bit rd, input logic [31:0] rpc,
                     input bit ue, input logic [31:0] upc, input bit ut, input logic [31:0] utg);
    bit          et;
    logic [31:0] etg;
    int          i;
    rst = r; stall_i = st; redirect_i = rd; redirect_pc_i = rpc;
    update_en_i = ue; update_pc_i = upc; update_taken_i = ut; update_target_i = utg;
    #1;
    if (known) begin
      lookup(mpc, et, etg);
      check("pc_o", pc_o, mpc);
      check("pred_taken_o", {31'b0, pred_taken_o}, {31'b0, et});
      check("pred_target_o", pred_target_o, etg);
    end
    if (!r) begin
      mpc = 32'h0;
      for (int k = 0; k < 16; k++) mv[k] = 1'b0;
      known = 1'b1;
    end else if (known) begin
      lookup(mpc, et, etg);
      if (ue && PRED_ON) begin
        i = int'((upc >> 2) % 16);
        if (mv[i] && mtag[i] == (upc >> 6)) begin
          if (ut) begin
            mctr[i] = (mctr[i] == 3) ? 3 : mctr[i] + 1;
            mtgt[i] = utg & ~32'h3;
          end else begin
            mctr[i] = (mctr[i] == 0) ? 0 : mctr[i] - 1;
          end
        end else if (ut) begin
          mv[i] = 1'b1; mtag[i] = upc >> 6; mtgt[i] = utg & ~32'h3; mctr[i] = 2;
        end
      end
      if (rd)      mpc = rpc & ~32'h3;
      else if (st) mpc = mpc;
      else if (et) mpc = etg;
      else         mpc = mpc + 32'h4;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cyc(1, 0, 0, 32'h0, 0, 32'h0, 0, 32'h0);
  endtask

  task automatic redirect(input logic [31:0] rpc);
    cyc(1, 0, 1, rpc, 0, 32'h0, 0, 32'h0);
  endtask

  task automatic update(input logic [31:0] upc, input bit ut, input logic [31:0] utg);
    cyc(1, 1, 0, 32'h0, 1, upc, ut, utg);
  endtask

  initial begin
    rst = 1'b0; stall_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = '0;
    update_en_i = 1'b0; update_pc_i = '0; update_taken_i = 1'b0; update_target_i = '0;

    cyc(0, 0, 0, 32'h0, 0, 32'h0, 0, 32'h0);
    cyc(0, 0, 0, 32'h0, 0, 32'h0, 0, 32'h0);
    check("reset_pc", pc_o, 32'h0);
    check("reset_pred", {31'b0, pred_taken_o}, 32'h0);
    repeat (4) idle();
    check("seq_pc", pc_o, 32'h10);

    // allocation at 0x10 -> 0x40
    cyc(1, 0, 0, 32'h0, 1, 32'h10, 1, 32'h40);
    redirect(32'h10);
    check("alloc_pred", {31'b0, pred_taken_o}, {31'b0, PRED_ON});
    check("alloc_target", pred_target_o, PRED_ON ? 32'h40 : 32'h0);
    idle();
    check("alloc_next", pc_o, PRED_ON ? 32'h40 : 32'h14);

    // saturation: 2 -> 3 -> 3 -> 3 -> 2 -> 1
    repeat (3) update(32'h10, 1, 32'h40);
    repeat (2) update(32'h10, 0, 32'h0);
    redirect(32'h10);
    check("sat_pred", {31'b0, pred_taken_o}, 32'h0);

    // priority: redirect beats stall and prediction; low bits of redirect ignored
    update(32'h100, 1, 32'h300);
    redirect(32'h100);
    cyc(1, 1, 1, 32'h203, 0, 32'h0, 0, 32'h0);
    check("prio_pc", pc_o, 32'h200);

    // aliasing and wrap
    update(32'h10, 1, 32'h80);
    redirect(32'h50);
    check("alias_pred", {31'b0, pred_taken_o}, 32'h0);
    redirect(32'hFFFF_FFFC);
    check("wrap_pred", {31'b0, pred_taken_o}, 32'h0);
    idle();
    check("wrap_pc", pc_o, 32'h0);

    // reset mid-operation discards the concurrent update
    cyc(0, 0, 1, 32'h500, 1, 32'h20, 1, 32'h99);
    check("midrst_pc", pc_o, 32'h0);
    redirect(32'h20);
    check("midrst_pred", {31'b0, pred_taken_o}, 32'h0);

    for (int n = 0; n < 400; n++) begin
      logic [31:0] rpc, upc, utg;
      rpc = ($urandom_range(0, 3) == 0 ? 32'hFFFF_FF00 : 32'h0) | 32'($urandom_range(0, 255));
      upc = ($urandom_range(0, 3) == 0 ? 32'h0000_1000 : 32'h0) | 32'($urandom_range(0, 63) << 2);
      utg = 32'($urandom_range(0, 255));
      cyc($urandom_range(0, 63) != 0, $urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0, rpc,
          $urandom_range(0, 1) == 1, upc, $urandom_range(0, 2) != 0, utg);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
